// File: rtl/coin_pkg.sv
// coin_pkg: shared FSM states, coin values and the loyalty-bonus helper for coin_acceptor.
package coin_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, LOAD, REFUND} state_t;

    localparam logic [10:0] COIN1_VAL  = 11'd1;
    localparam logic [10:0] COIN5_VAL  = 11'd5;
    localparam logic [10:0] COIN10_VAL = 11'd10;
    localparam logic [9:0]  BONUS_MIN  = 10'd50;

    // Large purchases get an extra tenth, clipped to what a 10-bit money bus can carry.
    function automatic logic [9:0] bonus_money(input logic [9:0] c);
        logic [10:0] b;
        b = {1'b0, c} + {1'b0, c / 10'd10};
        return (c < BONUS_MIN) ? c : ((b > 11'd1023) ? 10'd1023 : b[9:0]);
    endfunction

endpackage

// File: rtl/edge_det.sv
// edge_det: single-bit rising-edge detector; a level held high yields one pulse.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk) begin
        if (!rst_n) in_q <= 1'b0;
        else        in_q <= in;
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: coin credit accumulator feeding game_count with a set/money load strobe.
// Optional COIN_BONUS_EN: boosts money by credit/10 when credit >= 50.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int MAX_CREDIT  = 999,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_1,
    input  logic       coin_5,
    input  logic       coin_10,
    input  logic       start,
    input  logic       cancel,
    output logic       set,
    output logic [9:0] money,
    output logic [9:0] credit,
    output logic       reject,
    output logic       refund,
    output logic [9:0] refund_amt
);

    logic e1, e5, e10, es, ec;

    edge_det u_e1  (.clk(clk), .rst_n(rst_n), .in(coin_1),  .pulse(e1));
    edge_det u_e5  (.clk(clk), .rst_n(rst_n), .in(coin_5),  .pulse(e5));
    edge_det u_e10 (.clk(clk), .rst_n(rst_n), .in(coin_10), .pulse(e10));
    edge_det u_es  (.clk(clk), .rst_n(rst_n), .in(start),   .pulse(es));
    edge_det u_ec  (.clk(clk), .rst_n(rst_n), .in(cancel),  .pulse(ec));

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [10:0]      add, sum;
    logic [9:0]       credit_nx, load_val;
    logic             coin_any, open_st, accept;

    always_comb begin
        add       = (e1 ? COIN1_VAL : 11'd0) + (e5 ? COIN5_VAL : 11'd0) + (e10 ? COIN10_VAL : 11'd0);
        sum       = {1'b0, credit} + add;
        coin_any  = e1 | e5 | e10;
        open_st   = (state == IDLE) || (state == ACCUM);
        accept    = open_st && coin_any && (sum <= 11'(MAX_CREDIT));
        // LOAD/REFUND hand the credit out, so it empties on their way back to IDLE.
        credit_nx = open_st ? (accept ? sum[9:0] : credit) : 10'd0;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = accept ? ACCUM : IDLE;
            ACCUM:   state_nx = ec ? REFUND : es ? LOAD :
                                (cnt == CNT_W'(TIMEOUT_CYC - 1)) ? REFUND : ACCUM;
            default: state_nx = IDLE;
        endcase
        cnt_nx = (state_nx == ACCUM && !(coin_any | es | ec)) ? cnt + 1'b1 : '0;
`ifdef COIN_BONUS_EN
        load_val = bonus_money(credit_nx);
`else
        load_val = credit_nx;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            credit     <= '0;
            set        <= 1'b0;
            refund     <= 1'b0;
            reject     <= 1'b0;
            money      <= '0;
            refund_amt <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            credit     <= credit_nx;
            set        <= state_nx == LOAD;
            refund     <= state_nx == REFUND;
            reject     <= coin_any && !accept;
            money      <= (state_nx == LOAD) ? load_val : money;
            refund_amt <= (state_nx == REFUND) ? credit_nx : refund_amt;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed checks of coin_acceptor; build with +define+COIN_BONUS_EN for bonus values.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst_n, coin_1, coin_5, coin_10, start, cancel;
    logic       set, reject, refund;
    logic [9:0] money, credit, refund_amt;
    int         total = 0;
    int         bad = 0;
    int         waited;

    coin_acceptor dut (
        .clk(clk), .rst_n(rst_n), .coin_1(coin_1), .coin_5(coin_5), .coin_10(coin_10),
        .start(start), .cancel(cancel), .set(set), .money(money), .credit(credit),
        .reject(reject), .refund(refund), .refund_amt(refund_amt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // c = {coin_10, coin_5, coin_1}: one cycle high, one cycle low
    task automatic coin(input logic [2:0] c);
        {coin_10, coin_5, coin_1} = c;
        tick();
        {coin_10, coin_5, coin_1} = 3'b000;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        {coin_1, coin_5, coin_10, start, cancel} = '0;
        tick();
        tick();
        check("rst_set", set, 0);
        check("rst_money", money, 0);
        check("rst_credit", credit, 0);
        check("rst_reject", reject, 0);
        check("rst_refund", refund, 0);
        check("rst_amt", refund_amt, 0);
        rst_n = 1'b1;
        tick();

        coin(3'b010);
        check("c5", credit, 5);
        coin(3'b100);
        check("c15", credit, 15);
        coin(3'b001);
        check("c16", credit, 16);
        start = 1'b1;
        tick();
        check("load_set", set, 1);
        check("load_money", money, 16);
        check("load_refund", refund, 0);
        start = 1'b0;
        tick();
        check("post_set", set, 0);
        check("post_credit", credit, 0);
        check("post_money", money, 16);

        coin_10 = 1'b1;
        repeat (20) tick();
        coin_10 = 1'b0;
        tick();
        check("held_credit", credit, 10);
        cancel = 1'b1;
        tick();
        check("cancel_refund", refund, 1);
        check("cancel_amt", refund_amt, 10);
        cancel = 1'b0;
        tick();
        check("cancel_clr", credit, 0);
        check("cancel_pulse", refund, 0);

        repeat (99) coin(3'b100);
        coin(3'b010);
        check("c995", credit, 995);
        {coin_5, coin_1} = 2'b11;
        tick();
        check("sat_reject", reject, 1);
        check("sat_credit", credit, 995);
        {coin_5, coin_1} = 2'b00;
        tick();
        check("sat_reject_off", reject, 0);
        coin(3'b001);
        check("c996", credit, 996);
        cancel = 1'b1;
        tick();
        check("c996_amt", refund_amt, 996);
        cancel = 1'b0;
        tick();

        coin(3'b010);
        coin(3'b001);
        coin(3'b001);
        check("c7", credit, 7);
        start = 1'b1;
        cancel = 1'b1;
        tick();
        check("both_refund", refund, 1);
        check("both_amt", refund_amt, 7);
        check("both_set", set, 0);
        start = 1'b0;
        cancel = 1'b0;
        tick();
        check("both_refund_off", refund, 0);
        check("both_set_off", set, 0);

        coin(3'b001);
        coin(3'b001);
        coin(3'b001);
        check("c3", credit, 3);
        waited = 0;
        while (!refund && waited < 1100) begin
            tick();
            waited++;
        end
        check("timeout_cycles", waited, 999);
        check("timeout_amt", refund_amt, 3);
        tick();
        check("timeout_credit", credit, 0);
        start = 1'b1;
        tick();
        check("idle_start", set, 0);
        start = 1'b0;
        tick();

        repeat (6) coin(3'b100);
        start = 1'b1;
        tick();
        check("c60_set", set, 1);
`ifdef COIN_BONUS_EN
        check("c60_money", money, 66);
`else
        check("c60_money", money, 60);
`endif
        start = 1'b0;
        tick();
        repeat (4) coin(3'b100);
        start = 1'b1;
        tick();
        check("c40_money", money, 40);
        start = 1'b0;
        tick();

        coin(3'b010);
        start = 1'b1;
        tick();
        check("c5_load", set, 1);
        start = 1'b0;
        coin_1 = 1'b1;
        tick();
        check("load_coin_reject", reject, 1);
        check("load_coin_credit", credit, 0);
        coin_1 = 1'b0;
        tick();

        coin(3'b010);
        start = 1'b1;
        tick();
        check("pre_rst_set", set, 1);
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        check("abort_set", set, 0);
        check("abort_money", money, 0);
        check("abort_credit", credit, 0);
        check("abort_refund", refund, 0);
        check("abort_amt", refund_amt, 0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
